gen_run_ctrl: RTL and testbench

GEN_RUN_CTRL -- requirements
Module: gen_run_ctrl

---
 rtl/gen_ctrl_pkg.sv | 18 +
 rtl/gen_run_ctrl.sv | 107 ++++++++++
 tb/tb_gen_run_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_ctrl_pkg.sv
// rtl/gen_ctrl_pkg.sv - shared types and defaults for the generator run controller
package gen_ctrl_pkg;

    localparam int LEN_W_DEF  = 16;
    localparam int DATA_W_DEF = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // 00=8, 01=9, 10=10, 11=11 bit generator
    typedef logic [1:0] gen_mode_t;

endpackage

// File: rtl/gen_run_ctrl.sv
// rtl/gen_run_ctrl.sv - sequences one start/run/capture cycle of an external counter/LFSR
module gen_run_ctrl
    import gen_ctrl_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic              gen_start,
    output logic              gen_stop,
    output logic [1:0]        gen_mode,
    input  logic [DATA_W-1:0] gen_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [LEN_W-1:0]  rsp_cycles,
    output logic              rsp_aborted,
    output logic              busy
);

    state_e            r_state;
    gen_mode_t         r_mode;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_elapsed;
    logic              r_aborted;
    logic [DATA_W-1:0] r_rsp_data;
    logic [LEN_W-1:0]  r_rsp_cycles;
    logic              r_rsp_aborted;

    logic w_in_run;
    logic w_last;
    logic w_abort_exit;

    assign w_in_run     = (r_state == ST_RUN);
    assign w_last       = w_in_run && (r_elapsed == r_len - LEN_W'(1));
    // the final cycle always completes, so abort only wins before it
    assign w_abort_exit = w_in_run && abort && !w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mode        <= 2'b00;
            r_len         <= '0;
            r_elapsed     <= '0;
            r_aborted     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_cycles  <= '0;
            r_rsp_aborted <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_mode  <= cmd_mode;
                        r_len   <= cmd_len;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_elapsed <= '0;
                    r_aborted <= 1'b0;
                    r_state   <= (r_len != '0) ? ST_RUN : ST_HOLD;
                end
                ST_RUN: begin
                    if (w_abort_exit) begin
                        r_aborted <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_elapsed <= r_elapsed + LEN_W'(1);
                        if (w_last) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    r_rsp_data    <= gen_out;
                    r_rsp_cycles  <= r_elapsed;
                    r_rsp_aborted <= r_aborted;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign gen_start   = (r_state == ST_START);
    // the abort cycle must not advance the generator, so stop is raised combinationally
    assign gen_stop    = !((r_state == ST_START) || (w_in_run && !w_abort_exit));
    assign gen_mode    = r_mode;
    assign rsp_valid   = (r_state == ST_DONE);
    assign rsp_data    = r_rsp_data;
    assign rsp_cycles  = r_rsp_cycles;
    assign rsp_aborted = r_rsp_aborted;

endmodule

// File: tb/tb_gen_run_ctrl.sv
// tb/tb_gen_run_ctrl.sv - self-checking bench for gen_run_ctrl with an attached counter datapath
module tb_gen_run_ctrl;

    localparam int LEN_W  = 16;
    localparam int DATA_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [LEN_W-1:0]  cmd_len;
    logic              abort;
    logic              gen_start;
    logic              gen_stop;
    logic [1:0]        gen_mode;
    logic [DATA_W-1:0] gen_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [LEN_W-1:0]  rsp_cycles;
    logic              rsp_aborted;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gen_run_ctrl #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .abort(abort),
        .gen_start(gen_start), .gen_stop(gen_stop), .gen_mode(gen_mode),
        .gen_out(gen_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cycles(rsp_cycles), .rsp_aborted(rsp_aborted), .busy(busy)
    );

    // counter datapath: start clears, each non-stopped cycle advances modulo 2^(8+mode)
    logic [DATA_W-1:0] r_gen;
    always_ff @(posedge clk) begin
        if (rst || gen_start) r_gen <= '0;
        else if (!gen_stop)   r_gen <= DATA_W'((32'(r_gen) + 1) % (1 << (8 + int'(gen_mode))));
    end
    assign gen_out = r_gen;

    task automatic chk(input string name, input int got, input int exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // reference: abort on RUN cycle k (1-based) ends the run only when k < len
    task automatic model(input int mode, input int len, input int abort_at,
                         output int data, output int cycles, output int aborted, output int lat);
        bit early;
        early   = (abort_at != 0) && (abort_at < len);
        cycles  = early ? abort_at - 1 : len;
        aborted = early ? 1 : 0;
        data    = cycles % (1 << (8 + mode));
        lat     = (early ? abort_at : len) + 3;
    endtask

    task automatic run_cmd(input int mode, input int len, input int abort_at, input bit noise,
                           input int rdy_delay, output int data, output int cycles,
                           output int aborted, output int lat, output int starts,
                           output int adv, output int mode_ok);
        int run_len;
        int cyc;
        bit seen;
        run_len = (abort_at != 0 && abort_at < len) ? abort_at : len;
        starts = 0; adv = 0; lat = -1; mode_ok = 1; seen = 1'b0;
        data = -1; cycles = -1; aborted = -1;
        for (cyc = 1; cyc < len + 40; cyc++) begin
            @(negedge clk);
            cmd_valid = (cyc == 1);
            cmd_mode  = 2'(mode);
            cmd_len   = LEN_W'(len);
            abort     = (abort_at != 0 && cyc == abort_at + 2) ||
                        (noise && (cyc < 3 || cyc > run_len + 2));
            #1;
            if (cyc == 1) chk("accept_ready", int'(cmd_ready), 1);
            if (cyc > 1 && gen_mode != 2'(mode)) mode_ok = 0;
            if (rsp_valid) begin
                seen = 1'b1;
                lat = cyc - 1;
                break;
            end
            if (gen_start) starts++;
            if (!gen_stop && !gen_start) adv++;
        end
        if (!seen) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        data = int'(rsp_data); cycles = int'(rsp_cycles); aborted = int'(rsp_aborted);
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        abort = 1'b0;
        #1;
        chk("back_to_idle", int'(cmd_ready), 1);
    endtask

    typedef struct {
        int mode; int len; int abort_at; bit noise; int rdy;
        int e_data; int e_cycles; int e_aborted; int e_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d, c, a, l, s, v, m;
        int ed, ec, ea, el;
        vecs[0] = '{0, 300,  0, 1'b0, 0,  44,  300, 0,  303};
        vecs[1] = '{3,   0,  0, 1'b0, 0,   0,    0, 0,    3};
        vecs[2] = '{1, 100, 11, 1'b0, 0,  10,   10, 1,   14};
        vecs[3] = '{2,   8,  8, 1'b0, 0,   8,    8, 0,   11};
        vecs[4] = '{1, 600,  0, 1'b1, 2,  88,  600, 0,  603};
        vecs[5] = '{2,   1,  1, 1'b0, 0,   1,    1, 0,    4};
        vecs[6] = '{3,  20,  1, 1'b0, 1,   0,    0, 1,    4};
        vecs[7] = '{2,1030,  0, 1'b1, 0,   6, 1030, 0, 1033};

        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b11; cmd_len = '0;
        abort = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_gen_start", int'(gen_start), 0);
        chk("rst_gen_stop", int'(gen_stop), 1);
        chk("rst_gen_mode", int'(gen_mode), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_rsp_cycles", int'(rsp_cycles), 0);
        chk("rst_rsp_aborted", int'(rsp_aborted), 0);
        chk("rst_busy", int'(busy), 0);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].mode, vecs[i].len, vecs[i].abort_at, vecs[i].noise, vecs[i].rdy,
                    d, c, a, l, s, v, m);
            chk($sformatf("vec%0d_data", i), d, vecs[i].e_data);
            chk($sformatf("vec%0d_cycles", i), c, vecs[i].e_cycles);
            chk($sformatf("vec%0d_aborted", i), a, vecs[i].e_aborted);
            chk($sformatf("vec%0d_latency", i), l, vecs[i].e_lat);
            chk($sformatf("vec%0d_starts", i), s, 1);
            chk($sformatf("vec%0d_advance", i), v, vecs[i].e_cycles);
            chk($sformatf("vec%0d_mode", i), m, 1);
        end

        for (int i = 0; i < 24; i++) begin
            int rm, rl, ra;
            bit rn;
            rm = int'($urandom_range(0, 3));
            rl = int'($urandom_range(0, 200));
            ra = ($urandom_range(0, 2) == 0 || rl == 0) ? 0 : int'($urandom_range(1, rl + 5));
            rn = 1'($urandom_range(0, 1));
            model(rm, rl, ra, ed, ec, ea, el);
            run_cmd(rm, rl, ra, rn, int'($urandom_range(0, 3)), d, c, a, l, s, v, m);
            chk($sformatf("rnd%0d_data", i), d, ed);
            chk($sformatf("rnd%0d_cycles", i), c, ec);
            chk($sformatf("rnd%0d_aborted", i), a, ea);
            chk($sformatf("rnd%0d_latency", i), l, el);
            chk($sformatf("rnd%0d_advance", i), v, ec);
        end

        // DONE back-pressure: results stay stable and new commands are refused
        begin
            int cd, cc, ca, st;
            bit got;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_mode = 2'b01; cmd_len = LEN_W'(7);
            @(negedge clk);
            cmd_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge clk);
                #1;
                got = rsp_valid;
            end
            chk("stall_reached_done", int'(got), 1);
            cd = int'(rsp_data); cc = int'(rsp_cycles); ca = int'(rsp_aborted);
            chk("stall_data", cd, 7);
            chk("stall_cycles", cc, 7);
            st = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_len = LEN_W'(3); abort = 1'b1;
                #1;
                if (gen_start) st++;
                chk("stall_valid", int'(rsp_valid), 1);
                chk("stall_data_stable", int'(rsp_data), cd);
                chk("stall_cycles_stable", int'(rsp_cycles), cc);
                chk("stall_aborted_stable", int'(rsp_aborted), ca);
                chk("stall_cmd_ready", int'(cmd_ready), 0);
                chk("stall_gen_stop", int'(gen_stop), 1);
                chk("stall_gen_mode", int'(gen_mode), 1);
            end
            chk("stall_no_start", st, 0);
            @(negedge clk);
            cmd_valid = 1'b0; abort = 1'b0; rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            chk("stall_idle", int'(cmd_ready), 1);
            chk("stall_not_busy", int'(busy), 0);
        end

        // synchronous reset in the middle of a run
        begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_len = LEN_W'(50);
            @(negedge clk);
            cmd_valid = 1'b0;
            repeat (20) @(negedge clk);
            #1;
            chk("midrun_running", int'(gen_stop), 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("midrun_idle", int'(cmd_ready), 1);
            chk("midrun_gen_stop", int'(gen_stop), 1);
            chk("midrun_rsp_valid", int'(rsp_valid), 0);
            chk("midrun_busy", int'(busy), 0);
            chk("midrun_gen_mode", int'(gen_mode), 0);
            @(negedge clk);
            #1;
            chk("midrun_stays_idle", int'(busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
